i2c_req_arbiter: RTL and testbench
==================================

Name: i2c_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one I2C master peripheral between NREQ local requesters.
- Each granted transaction is turned into byte-enabled register accesses on the master's register bus: NBY, ADR, TDR, CFG writes.
- It then polls CFG for the done flag, fetches RDR for reads, clears CFG, and returns data and status to the requester.
- Sits between requester blocks and the I2C master's register port. It is the only writer of that port.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 65535, maximum POLL cycles before a transaction is aborted with error.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  NREQ  per-requester request level
- rw_i  in  NREQ  per-requester 1=read, 0=write
- dev_addr_i  in  7*NREQ  per-requester 7-bit device address, slice k = [7k+:7]
- nbytes_i  in  3*NREQ  per-requester byte count 1..4, slice k = [3k+:3]
- wdata_i  in  32*NREQ  per-requester write data, byte 0 in bits [7:0]
- gnt_o  out  NREQ  one-hot grant
- done_o  out  NREQ  one-cycle completion pulse
- err_o  out  1  error flag, valid while any done_o bit is high
- rdata_o  out  32  read data, valid while done_o is high
- busy_o  out  1  high whenever state is not IDLE
- write_o  out  1  master register write strobe
- data_be_o  out  4  master byte enables
- addr_o  out  5  master register byte address
- wdata_o  out  32  master register write data
- rdata_i  in  32  master register read data; combinational from addr_o/data_be_o, sampled in the same cycle

Behaviour:
- Reset:
  - state=IDLE; rr_ptr=0; timeout counter=0.
  - gnt_o, done_o, err_o, rdata_o, busy_o, write_o, data_be_o, addr_o, wdata_o all 0.
  - Reset mid-transaction aborts immediately with no done_o pulse.
- Arbitration (IDLE only):
  - Search req_i starting at rr_ptr, wrapping modulo NREQ. The first set bit wins.
  - Latch winner index g and its rw, dev_addr, nbytes, wdata. gnt_o[g]=1 from the next cycle through DONE inclusive.
  - Requests arriving while not IDLE wait; they are never lost while req_i is held.
- Byte count:
  - nbytes 1..4 maps to NBY field = nbytes[1:0] (4 encodes as 0).
  - nbytes 0 or 5..7: go directly to DONE with err_o=1 and rdata_o=0; no bus access.
- Bus outputs: all zero in states that do not access the bus.
- States, one cycle each unless noted:
  - WR_NBY: write_o=1, addr_o=0x00, data_be_o=0001, wdata_o={30'b0, NBY}.
  - WR_ADR: write_o=1, addr_o=0x04, data_be_o=0001, wdata_o={25'b0, dev_addr}.
  - WR_TDR: write transactions only; reads skip it. write_o=1, addr_o=0x0C, data_be_o=1111, wdata_o=wdata.
  - WR_CFG: write_o=1, addr_o=0x10, data_be_o=0001, wdata_o = 0x1 for a write or 0x4 for a read. Clear the timeout counter.
  - POLL (multi-cycle):
    - write_o=0, addr_o=0x10, data_be_o=0001; sample rdata_i.
    - Done bit is rdata_i[1] for a write, rdata_i[3] for a read.
    - Done set: go to RD_RDR for a read, CLR for a write.
    - Else: counter+1. When counter reaches TIMEOUT-1, set err flag and go to CLR. This covers an address NACK, where the master stops without setting done.
  - RD_RDR: addr_o=0x08, data_be_o=1111; latch rdata_i into the result register.
  - CLR: write_o=1, addr_o=0x10, data_be_o=0001, wdata_o=0 (returns master CFG to idle).
  - DONE:
    - done_o[g]=1, err_o=err flag, rdata_o=result.
    - rdata_o is 0 for writes and on error.
    - rr_ptr=(g+1) mod NREQ. Next state is IDLE.
- After DONE, done_o, err_o and rdata_o return to 0.
- A requester whose req_i is still high after its done_o pulse is re-arbitrated behind the others.
- Requesters hold rw/addr/nbytes/wdata stable only until the grant cycle; values are latched.
- Latency:
  - Write: 4 bus cycles + P POLL cycles + CLR + DONE.
  - Read: 3 bus cycles + P POLL cycles + RD_RDR + CLR + DONE.
  - IDLE with request to gnt_o high: 1 cycle.

Test Plan:
- Single write: req0, rw=0, addr=0x50, nbytes=2, wdata=0xA5C3 → bus writes 0x00←2, 0x04←0x50, 0x0C←0x0000A5C3, 0x10←1. Slave model sets CFG=0x3 after 10 polls → CLR writes 0; done_o[0] pulse, err_o=0, rdata_o=0.
- Single read: req2, rw=1, addr=0x21, nbytes=4; master RDR=0xDEADBEEF → no 0x0C access, CFG←4, done on bit3 → done_o[2] with rdata_o=0xDEADBEEF.
- Round-robin: req_i=1111 held for all requesters → grant order 0,1,2,3,0. A requester re-requesting after done is served after the other three.
- Timeout: TIMEOUT=16, CFG done bit never set → exactly 16 POLL cycles, then CLR, then done_o with err_o=1 and rdata_o=0.
- Bad length: nbytes=0 and nbytes=5 → done_o the cycle after grant with err_o=1, write_o never asserted.
- Reset mid-POLL: assert rst_i during POLL → next cycle all outputs 0, state IDLE, no done_o; a pending req_i is granted again from rr_ptr=0 after reset is released.

Source files
------------

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one I2C master register port between NREQ requesters,
// sequencing NBY/ADR/TDR/CFG writes, CFG polling, RDR fetch and CFG clear per transaction.
module i2c_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ-1:0]      rw_i,
    input  logic [7*NREQ-1:0]    dev_addr_i,
    input  logic [3*NREQ-1:0]    nbytes_i,
    input  logic [32*NREQ-1:0]   wdata_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      done_o,
    output logic                 err_o,
    output logic [31:0]          rdata_o,
    output logic                 busy_o,
    output logic                 write_o,
    output logic [3:0]           data_be_o,
    output logic [4:0]           addr_o,
    output logic [31:0]          wdata_o,
    input  logic [31:0]          rdata_i
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        WR_NBY = 4'd1,
        WR_ADR = 4'd2,
        WR_TDR = 4'd3,
        WR_CFG = 4'd4,
        POLL   = 4'd5,
        RD_RDR = 4'd6,
        CLR    = 4'd7,
        DONE   = 4'd8
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic [IW-1:0]   rr_ptr_r;
    logic [IW-1:0]   gidx_r;
    logic [CW-1:0]   cnt_r;
    logic            rw_r;
    logic [6:0]      dev_r;
    logic [2:0]      nby_r;
    logic [31:0]     wdat_r;
    logic            err_r;
    logic [31:0]     res_r;

    logic            found_s;
    logic [IW-1:0]   win_s;
    logic [IW-1:0]   sel_g_s;
    logic            sel_rw_s;
    logic [6:0]      sel_dev_s;
    logic [2:0]      sel_nby_s;
    logic [31:0]     sel_wdata_s;
    logic            sel_err_s;
    logic            bad_len_s;
    logic            done_bit_s;
    logic            poll_last_s;

    logic            nxt_write_s;
    logic [3:0]      nxt_be_s;
    logic [4:0]      nxt_addr_s;
    logic [31:0]     nxt_wdata_s;

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [NREQ-1:0] v;
        v = {NREQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin search of req_i starting at rr_ptr_r
    always_comb begin
        found_s = 1'b0;
        win_s   = {IW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (!found_s && req_i[(int'(rr_ptr_r) + i) % NREQ]) begin
                found_s = 1'b1;
                win_s   = IW'((int'(rr_ptr_r) + i) % NREQ);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Transaction fields: live winner inputs while IDLE, latched copies afterwards
    always_comb begin
        if (state_r == IDLE) begin
            sel_g_s     = win_s;
            sel_rw_s    = rw_i[win_s];
            sel_dev_s   = dev_addr_i[int'(win_s)*7 +: 7];
            sel_nby_s   = nbytes_i[int'(win_s)*3 +: 3];
            sel_wdata_s = wdata_i[int'(win_s)*32 +: 32];
        end else begin
            sel_g_s     = gidx_r;
            sel_rw_s    = rw_r;
            sel_dev_s   = dev_r;
            sel_nby_s   = nby_r;
            sel_wdata_s = wdat_r;
        end
        bad_len_s   = (sel_nby_s == 3'd0) || (sel_nby_s > 3'd4);
        sel_err_s   = (state_r == IDLE) ? bad_len_s : err_r;
        done_bit_s  = rw_r ? rdata_i[3] : rdata_i[1];
        poll_last_s = (cnt_r == CNT_LAST);
    end

    // Next-state decision
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    next_state_s = bad_len_s ? DONE : WR_NBY;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WR_NBY: next_state_s = WR_ADR;
            WR_ADR: next_state_s = rw_r ? WR_CFG : WR_TDR;
            WR_TDR: next_state_s = WR_CFG;
            WR_CFG: next_state_s = POLL;
            POLL: begin
                if (done_bit_s) begin
                    next_state_s = rw_r ? RD_RDR : CLR;
                end else if (poll_last_s) begin
                    next_state_s = CLR;
                end else begin
                    next_state_s = POLL;
                end
            end
            RD_RDR: next_state_s = CLR;
            CLR:    next_state_s = DONE;
            DONE:   next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Bus access values for the state about to be entered, so the port is registered
    always_comb begin
        nxt_write_s = 1'b0;
        nxt_be_s    = 4'h0;
        nxt_addr_s  = 5'h00;
        nxt_wdata_s = 32'h0000_0000;
        case (next_state_s)
            WR_NBY: begin
                nxt_write_s = 1'b1;
                nxt_be_s    = 4'h1;
                nxt_addr_s  = 5'h00;
                nxt_wdata_s = {30'h0, sel_nby_s[1:0]};
            end
            WR_ADR: begin
                nxt_write_s = 1'b1;
                nxt_be_s    = 4'h1;
                nxt_addr_s  = 5'h04;
                nxt_wdata_s = {25'h0, sel_dev_s};
            end
            WR_TDR: begin
                nxt_write_s = 1'b1;
                nxt_be_s    = 4'hF;
                nxt_addr_s  = 5'h0C;
                nxt_wdata_s = sel_wdata_s;
            end
            WR_CFG: begin
                nxt_write_s = 1'b1;
                nxt_be_s    = 4'h1;
                nxt_addr_s  = 5'h10;
                nxt_wdata_s = sel_rw_s ? 32'h0000_0004 : 32'h0000_0001;
            end
            POLL: begin
                nxt_be_s   = 4'h1;
                nxt_addr_s = 5'h10;
            end
            RD_RDR: begin
                nxt_be_s   = 4'hF;
                nxt_addr_s = 5'h08;
            end
            CLR: begin
                nxt_write_s = 1'b1;
                nxt_be_s    = 4'h1;
                nxt_addr_s  = 5'h10;
            end
            default: begin
                nxt_write_s = 1'b0;
                nxt_be_s    = 4'h0;
                nxt_addr_s  = 5'h00;
                nxt_wdata_s = 32'h0000_0000;
            end
        endcase
    end

    // Sequencer state, transaction context and all registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            rr_ptr_r  <= {IW{1'b0}};
            gidx_r    <= {IW{1'b0}};
            cnt_r     <= {CW{1'b0}};
            rw_r      <= 1'b0;
            dev_r     <= 7'h00;
            nby_r     <= 3'd0;
            wdat_r    <= 32'h0000_0000;
            err_r     <= 1'b0;
            res_r     <= 32'h0000_0000;
            gnt_o     <= {NREQ{1'b0}};
            done_o    <= {NREQ{1'b0}};
            err_o     <= 1'b0;
            rdata_o   <= 32'h0000_0000;
            busy_o    <= 1'b0;
            write_o   <= 1'b0;
            data_be_o <= 4'h0;
            addr_o    <= 5'h00;
            wdata_o   <= 32'h0000_0000;
        end else begin
            state_r <= next_state_s;
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        gidx_r <= win_s;
                        rw_r   <= sel_rw_s;
                        dev_r  <= sel_dev_s;
                        nby_r  <= sel_nby_s;
                        wdat_r <= sel_wdata_s;
                        err_r  <= bad_len_s;
                        res_r  <= 32'h0000_0000;
                    end else begin
                        gidx_r <= gidx_r;
                    end
                end
                WR_CFG: cnt_r <= {CW{1'b0}};
                POLL: begin
                    if (done_bit_s) begin
                        cnt_r <= cnt_r;
                    end else if (poll_last_s) begin
                        err_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                RD_RDR: res_r <= rdata_i;
                DONE: rr_ptr_r <= (gidx_r == IW'(NREQ - 1)) ? {IW{1'b0}} : gidx_r + 1'b1;
                default: cnt_r <= cnt_r;
            endcase

            gnt_o     <= (next_state_s != IDLE) ? onehot(sel_g_s) : {NREQ{1'b0}};
            done_o    <= (next_state_s == DONE) ? onehot(sel_g_s) : {NREQ{1'b0}};
            err_o     <= (next_state_s == DONE) && sel_err_s;
            // Read data is only returned for a successful read
            rdata_o   <= ((next_state_s == DONE) && !sel_err_s && sel_rw_s) ? res_r : 32'h0000_0000;
            busy_o    <= (next_state_s != IDLE);
            write_o   <= nxt_write_s;
            data_be_o <= nxt_be_s;
            addr_o    <= nxt_addr_s;
            wdata_o   <= nxt_wdata_s;
        end
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter with a behavioural I2C master register model.
module tb_i2c_req_arbiter;

    localparam int NREQ = 4;
    localparam int TO   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   rw = '0;
    logic [7*NREQ-1:0] dev = '0;
    logic [3*NREQ-1:0] nby = '0;
    logic [32*NREQ-1:0] wd = '0;
    logic [NREQ-1:0]   gnt, done;
    logic              err, busy, wr;
    logic [31:0]       rdata, bwdata, rdata_in;
    logic [3:0]        be;
    logic [4:0]        addr;

    int          n_chk = 0;
    int          n_err = 0;
    int          poll_cnt = 0;
    int          done_seen = 0;
    int          done_after = 1000;
    logic [31:0] cfg_done_val = 32'h0;
    logic [31:0] rdr_val = 32'h0;
    logic [3:0]  last_done = '0;
    logic        last_err = 1'b0;
    logic [31:0] last_rdata = '0;
    logic [40:0] wlog[$];
    logic [3:0]  dlog[$];

    i2c_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .rw_i(rw), .dev_addr_i(dev),
        .nbytes_i(nby), .wdata_i(wd), .gnt_o(gnt), .done_o(done), .err_o(err),
        .rdata_o(rdata), .busy_o(busy), .write_o(wr), .data_be_o(be),
        .addr_o(addr), .wdata_o(bwdata), .rdata_i(rdata_in)
    );

    always #5 clk = ~clk;

    // Master register model: CFG reports done after done_after completed polls
    always_comb begin
        rdata_in = 32'h0;
        if (addr == 5'h10) rdata_in = (poll_cnt >= done_after) ? cfg_done_val : 32'h0;
        else if (addr == 5'h08) rdata_in = rdr_val;
    end

    // Bus and completion monitor
    always @(posedge clk) begin
        if (wr && addr == 5'h10 && bwdata != 32'h0) poll_cnt <= 0;
        else if (!wr && addr == 5'h10 && be == 4'h1) poll_cnt <= poll_cnt + 1;
        if (wr) wlog.push_back({addr, be, bwdata});
        if (|done) begin
            done_seen  <= done_seen + 1;
            last_done  <= done;
            last_err   <= err;
            last_rdata <= rdata;
            dlog.push_back(done);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_gnt"}, 64'(gnt), 64'h0);
        check_eq({tag, "_done"}, 64'(done), 64'h0);
        check_eq({tag, "_err_busy"}, 64'({err, busy}), 64'h0);
        check_eq({tag, "_rdata"}, 64'(rdata), 64'h0);
        check_eq({tag, "_bus"}, 64'({wr, be, addr, bwdata}), 64'h0);
    endtask

    // Raise one request while the arbiter is idle and check the grant timing
    task automatic do_req(input int k, input logic r, input logic [6:0] a,
                          input logic [2:0] n, input logic [31:0] d, input bit bad);
        @(posedge clk); #1;
        rw[k] = r; dev[7*k +: 7] = a; nby[3*k +: 3] = n; wd[32*k +: 32] = d; req[k] = 1'b1;
        @(posedge clk); @(negedge clk);
        check_eq("gnt_latency", 64'(gnt), 64'(4'b0001 << k));
        check_eq("done_early", 64'(done), bad ? 64'(4'b0001 << k) : 64'h0);
    endtask

    task automatic wait_done(input int start, input string tag);
        int n = 0;
        while (done_seen == start && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 64'(done_seen - start), 64'h1);
    endtask

    initial begin
        int base, s, n;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, s, n;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        #1 rst = 1'b0;

        // Single write on requester 0
        base = wlog.size(); s = done_seen; done_after = 10; cfg_done_val = 32'h3;
        do_req(0, 1'b0, 7'h50, 3'd2, 32'h0000_A5C3, 1'b0);
        wait_done(s, "wr_done_seen");
        req[0] = 1'b0;
        check_eq("wr_nlog", 64'(wlog.size() - base), 64'd5);
        check_eq("wr_nby", 64'(wlog[base+0]), 64'({5'h00, 4'h1, 32'h2}));
        check_eq("wr_adr", 64'(wlog[base+1]), 64'({5'h04, 4'h1, 32'h50}));
        check_eq("wr_tdr", 64'(wlog[base+2]), 64'({5'h0C, 4'hF, 32'h0000_A5C3}));
        check_eq("wr_cfg", 64'(wlog[base+3]), 64'({5'h10, 4'h1, 32'h1}));
        check_eq("wr_clr", 64'(wlog[base+4]), 64'({5'h10, 4'h1, 32'h0}));
        check_eq("wr_polls", 64'(poll_cnt), 64'd11);
        check_eq("wr_done_vec", 64'(last_done), 64'h1);
        check_eq("wr_err_rdata", 64'({last_err, last_rdata}), 64'h0);
        @(negedge clk);
        check_eq("wr_busy_after", 64'(busy), 64'h0);

        // Single read on requester 2: no TDR access, data from RDR
        base = wlog.size(); s = done_seen; done_after = 3; cfg_done_val = 32'hC; rdr_val = 32'hDEAD_BEEF;
        do_req(2, 1'b1, 7'h21, 3'd4, 32'h0, 1'b0);
        wait_done(s, "rd_done_seen");
        req[2] = 1'b0;
        check_eq("rd_nlog", 64'(wlog.size() - base), 64'd4);
        check_eq("rd_nby", 64'(wlog[base+0]), 64'({5'h00, 4'h1, 32'h0}));
        check_eq("rd_adr", 64'(wlog[base+1]), 64'({5'h04, 4'h1, 32'h21}));
        check_eq("rd_cfg", 64'(wlog[base+2]), 64'({5'h10, 4'h1, 32'h4}));
        check_eq("rd_clr", 64'(wlog[base+3]), 64'({5'h10, 4'h1, 32'h0}));
        check_eq("rd_done_vec", 64'(last_done), 64'h4);
        check_eq("rd_err", 64'(last_err), 64'h0);
        check_eq("rd_rdata", 64'(last_rdata), 64'hDEAD_BEEF);

        // Round robin with all four requests held
        do_reset();
        base = dlog.size(); done_after = 0; cfg_done_val = 32'h3;
        for (int k = 0; k < NREQ; k++) begin
            rw[k] = 1'b0; dev[7*k +: 7] = 7'(k + 8); nby[3*k +: 3] = 3'd1; wd[32*k +: 32] = 32'(k);
        end
        req = 4'hF;
        n = 0;
        while (dlog.size() < base + 5 && n < 400) begin
            @(negedge clk);
            n++;
        end
        req = 4'h0;
        check_eq("rr_count", 64'(dlog.size() - base), 64'd5);
        check_eq("rr_order0", 64'(dlog[base+0]), 64'h1);
        check_eq("rr_order1", 64'(dlog[base+1]), 64'h2);
        check_eq("rr_order2", 64'(dlog[base+2]), 64'h4);
        check_eq("rr_order3", 64'(dlog[base+3]), 64'h8);
        check_eq("rr_order4", 64'(dlog[base+4]), 64'h1);
        do_reset();

        // Timeout on a read: done bit never set
        base = wlog.size(); s = done_seen; done_after = 1000; rdr_val = 32'h1234_5678;
        do_req(1, 1'b1, 7'h33, 3'd3, 32'h0, 1'b0);
        wait_done(s, "to_done_seen");
        req[1] = 1'b0;
        check_eq("to_polls", 64'(poll_cnt), 64'd16);
        check_eq("to_nlog", 64'(wlog.size() - base), 64'd4);
        check_eq("to_clr", 64'(wlog[base+3]), 64'({5'h10, 4'h1, 32'h0}));
        check_eq("to_done_vec", 64'(last_done), 64'h2);
        check_eq("to_err", 64'(last_err), 64'h1);
        check_eq("to_rdata", 64'(last_rdata), 64'h0);

        // Bad lengths: nbytes=5 then nbytes=0, no bus traffic
        base = wlog.size(); s = done_seen;
        do_req(0, 1'b0, 7'h10, 3'd5, 32'h55, 1'b1);
        wait_done(s, "bad5_done_seen");
        req[0] = 1'b0;
        check_eq("bad5_done_vec", 64'(last_done), 64'h1);
        check_eq("bad5_err_rdata", 64'({last_err, last_rdata}), 64'({1'b1, 32'h0}));
        s = done_seen;
        do_req(2, 1'b1, 7'h11, 3'd0, 32'h0, 1'b1);
        wait_done(s, "bad0_done_seen");
        req[2] = 1'b0;
        check_eq("bad0_done_vec", 64'(last_done), 64'h4);
        check_eq("bad0_err_rdata", 64'({last_err, last_rdata}), 64'({1'b1, 32'h0}));
        check_eq("bad_nlog", 64'(wlog.size() - base), 64'h0);

        // Reset during POLL; round-robin pointer restarts at 0
        done_after = 1000; cfg_done_val = 32'h3;
        do_req(3, 1'b0, 7'h44, 3'd1, 32'h11, 1'b0);
        rw[1] = 1'b0; dev[7 +: 7] = 7'h45; nby[3 +: 3] = 3'd1; wd[32 +: 32] = 32'h22; req[1] = 1'b1;
        n = 0;
        while (poll_cnt < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("rst_reached_poll", 64'(poll_cnt >= 3), 64'h1);
        s = done_seen;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check_quiet("rst_mid");
        done_after = 2;
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check_eq("rst_regrant", 64'(gnt), 64'h2);
        req = 4'h0;
        wait_done(s, "rst_done_seen");
        check_eq("rst_done_vec", 64'(last_done), 64'h2);
        check_eq("rst_err", 64'(last_err), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
